// File: rtl/wram_xfer_sequencer_if.sv
// Bus bundle for the WRAM transfer sequencer: control, RV arbiter
// port, save stream and load stream.
interface wram_xfer_sequencer_if;
    logic        i_start;
    logic        i_dir;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_wram_load_ongoing;
    logic        o_wram_save_ongoing;
    logic [22:0] o_rv_addr;
    logic        o_rv_word;
    logic [31:0] o_rv_wdata;
    logic [1:0]  o_rv_ds;
    logic [3:0]  o_rv_wstrb;
    logic        o_rv_req;
    logic        i_rv_req_ack;
    logic [15:0] i_rv_dout;
    logic [7:0]  o_sv_data;
    logic        o_sv_valid;
    logic        i_sv_ready;
    logic [7:0]  i_ld_data;
    logic        i_ld_valid;
    logic        o_ld_ready;

    modport master (
        input  i_start, i_dir, i_abort,
        input  i_rv_req_ack, i_rv_dout,
        input  i_sv_ready, i_ld_data, i_ld_valid,
        output o_busy, o_done, o_error,
        output o_wram_load_ongoing, o_wram_save_ongoing,
        output o_rv_addr, o_rv_word, o_rv_wdata,
        output o_rv_ds, o_rv_wstrb, o_rv_req,
        output o_sv_data, o_sv_valid, o_ld_ready
    );

    modport slave (
        output i_start, i_dir, i_abort,
        output i_rv_req_ack, i_rv_dout,
        output i_sv_ready, i_ld_data, i_ld_valid,
        input  o_busy, o_done, o_error,
        input  o_wram_load_ongoing, o_wram_save_ongoing,
        input  o_rv_addr, o_rv_word, o_rv_wdata,
        input  o_rv_ds, o_rv_wstrb, o_rv_req,
        input  o_sv_data, o_sv_valid, o_ld_ready
    );
endinterface

// File: rtl/wram_xfer_sequencer.sv
// Byte-wise WRAM save/load sequencer: moves XFER_SIZE bytes between
// the SDRAM arbiter (toggle request/ack) and an 8-bit stream.
module wram_xfer_sequencer #(
    parameter logic [22:0] BASE_ADDR   = 23'h706000,
    parameter int          XFER_SIZE   = 'h2000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    wram_xfer_sequencer_if.master         bus
);

    localparam int          TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [12:0] LAST_IDX = 13'(XFER_SIZE - 1);
    localparam logic [TW-1:0] TMO_END = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        REQ,
        WAIT_ACK,
        SV_PUSH,
        NEXT,
        FIN
    } state_t;

    state_t        state, state_n;
    logic          dir, dir_n;
    logic [12:0]   idx, idx_n;
    logic          err, err_n;
    logic          abort_q, abort_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    ld_byte, ld_byte_n;
    logic [7:0]    sv_data, sv_data_n;
    logic          rv_req, rv_req_n;
    logic [22:0]   rv_addr, rv_addr_n;
    logic [31:0]   rv_wdata, rv_wdata_n;
    logic [1:0]    rv_ds, rv_ds_n;
    logic [3:0]    rv_wstrb, rv_wstrb_n;
    logic          ack_seen;

    assign ack_seen = (bus.i_rv_req_ack == rv_req);

    // Next-state logic; request fields are latched on entry to REQ
    // so they stay frozen until the arbiter acknowledges.
    always_comb begin
        state_n    = state;
        dir_n      = dir;
        idx_n      = idx;
        err_n      = err;
        abort_n    = abort_q;
        tmo_n      = tmo;
        ld_byte_n  = ld_byte;
        sv_data_n  = sv_data;
        rv_req_n   = rv_req;
        rv_addr_n  = rv_addr;
        rv_wdata_n = rv_wdata;
        rv_ds_n    = rv_ds;
        rv_wstrb_n = rv_wstrb;

        unique case (state)
            IDLE: begin
                abort_n = 1'b0;
                if (bus.i_start) begin
                    dir_n   = bus.i_dir;
                    idx_n   = '0;
                    err_n   = 1'b0;
                    state_n = bus.i_dir ? LD_WAIT : REQ;
                end
            end
            LD_WAIT: begin
                if (bus.i_abort) begin
                    state_n = IDLE;
                end else if (bus.i_ld_valid) begin
                    ld_byte_n = bus.i_ld_data;
                    state_n   = REQ;
                end
            end
            REQ: begin
                abort_n  = abort_q | bus.i_abort;
                tmo_n    = '0;
                rv_req_n = ~rv_req;
                state_n  = WAIT_ACK;
            end
            WAIT_ACK: begin
                abort_n = abort_q | bus.i_abort;
                if (ack_seen) begin
                    if (abort_n) begin
                        state_n = IDLE;
                    end else if (dir) begin
                        state_n = NEXT;
                    end else begin
                        sv_data_n = rv_addr[0] ? bus.i_rv_dout[15:8]
                                               : bus.i_rv_dout[7:0];
                        state_n   = SV_PUSH;
                    end
                end else if (tmo == TMO_END) begin
                    err_n   = 1'b1;
                    state_n = abort_n ? IDLE : FIN;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            SV_PUSH: begin
                if (bus.i_abort) begin
                    state_n = IDLE;
                end else if (bus.i_sv_ready) begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (bus.i_abort) begin
                    state_n = IDLE;
                end else if (idx == LAST_IDX) begin
                    state_n = FIN;
                end else begin
                    idx_n   = idx + 13'd1;
                    state_n = dir ? LD_WAIT : REQ;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n == REQ) begin
            rv_addr_n  = BASE_ADDR + 23'(idx_n);
            rv_ds_n    = rv_addr_n[0] ? 2'b10 : 2'b01;
            rv_wstrb_n = dir_n ? (4'b0001 << rv_addr_n[1:0]) : 4'b0000;
            rv_wdata_n = {4{ld_byte_n}};
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            dir      <= 1'b0;
            idx      <= '0;
            err      <= 1'b0;
            abort_q  <= 1'b0;
            tmo      <= '0;
            ld_byte  <= '0;
            sv_data  <= '0;
            rv_req   <= 1'b0;
            rv_addr  <= '0;
            rv_wdata <= '0;
            rv_ds    <= '0;
            rv_wstrb <= '0;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            idx      <= idx_n;
            err      <= err_n;
            abort_q  <= abort_n;
            tmo      <= tmo_n;
            ld_byte  <= ld_byte_n;
            sv_data  <= sv_data_n;
            rv_req   <= rv_req_n;
            rv_addr  <= rv_addr_n;
            rv_wdata <= rv_wdata_n;
            rv_ds    <= rv_ds_n;
            rv_wstrb <= rv_wstrb_n;
        end
    end

    // Status and stream handshake outputs decoded from state.
    always_comb begin
        bus.o_busy              = (state != IDLE);
        bus.o_done              = (state == FIN);
        bus.o_sv_valid          = (state == SV_PUSH);
        bus.o_ld_ready          = (state == LD_WAIT);
        bus.o_wram_load_ongoing = (state != IDLE) && dir;
        bus.o_wram_save_ongoing = (state != IDLE) && !dir;
    end

    assign bus.o_error    = err;
    assign bus.o_rv_addr  = rv_addr;
    assign bus.o_rv_word  = rv_addr[1];
    assign bus.o_rv_wdata = rv_wdata;
    assign bus.o_rv_ds    = rv_ds;
    assign bus.o_rv_wstrb = rv_wstrb;
    assign bus.o_rv_req   = rv_req;
    assign bus.o_sv_data  = sv_data;

endmodule
